dual_lsu: RTL and testbench
===========================

Name: dual_lsu

Overview:
Dual-lane load/store unit for the MEM stage of the superscalar pipeline; it is the initiator side of the dual-port data memory.
- Accepts one memory request per lane per cycle, drives both memory ports and tracks the 1-cycle registered read latency.
- Returns tagged load data to writeback.
- Resolves an intra-pair store(lane 1) -> load(lane 2) same-word hazard by splitting the pair over two cycles.

Parameters:
TAG_W, 5, width of destination-register tag carried with each request
ADDR_BITS, 8, low address bits that select a memory word; used for hazard compare

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid_1  input  1  lane 1 request present
req_we_1  input  1  lane 1: 1 = store, 0 = load
req_addr_1  input  32  lane 1 word address
req_wdata_1  input  32  lane 1 store data
req_tag_1  input  TAG_W  lane 1 destination tag (loads)
req_valid_2, req_we_2, req_addr_2, req_wdata_2, req_tag_2  input  1/1/32/32/TAG_W  lane 2 equivalents
req_ready  output  1  pair accepted this cycle when high
mem_address_1, mem_address_2  output  32  to memory ports 1/2
mem_write_data_1, mem_write_data_2  output  32  store data to memory
mem_memwrite_1, mem_memwrite_2  output  1  write strobes
mem_memread_1, mem_memread_2  output  1  read strobes
mem_read_data_1, mem_read_data_2  input  32  registered read data from memory
resp_valid_1, resp_valid_2  output  1  load result valid on lane
resp_data_1, resp_data_2  output  32  load result
resp_tag_1, resp_tag_2  output  TAG_W  tag of returned load
split_count  output  16  saturating count of split pairs

Behaviour:
- States: RUN, SPLIT. Reset -> RUN. Reset values:
  - resp_valid_* = 0, resp_tag_* = 0, split_count = 0.
  - Deferred lane-2 register cleared.
  - All mem strobes 0 in the cycle after reset.
- req_ready = 1 in RUN, 0 in SPLIT; combinational from state only.
- Hazard condition: req_valid_1 & req_we_1 & req_valid_2 & !req_we_2 & (req_addr_1[ADDR_BITS-1:0] == req_addr_2[ADDR_BITS-1:0]).
- RUN, no hazard:
  - mem port n is driven combinationally from lane n.
  - memwrite_n = valid_n & we_n; memread_n = valid_n & !we_n.
  - Address and write data pass through unchanged.
- RUN, hazard:
  - Only port 1 is driven (store); port 2 strobes = 0.
  - Lane 2 addr/tag is latched into the deferred register.
  - split_count increments, saturating at 16'hFFFF.
  - Next state SPLIT.
- SPLIT:
  - Port 2 issues the deferred load (memread_2 = 1, address from the deferred register); port 1 strobes = 0.
  - Next state RUN.
  - Lane request inputs are ignored during this cycle.
- Both-store same word: no split. Issue both; lane 2 data wins. Memory write ordering guarantees this.
- Load(lane 1) + store(lane 2) same word: no split. The load returns the pre-store value, which is correct program order.
- Read latency: resp_valid_n is registered at the edge following a read issue on port n. resp_tag_n is registered at the same edge. resp_data_n = mem_read_data_n combinationally.
- resp_valid_n is a single-cycle pulse per issued load; stores produce no response.
- Back-to-back loads give one response per cycle per lane with no bubbles.
- Reset asserted in SPLIT:
  - Deferred load is dropped: no memread, no response.
  - State returns to RUN; req_ready = 1 the cycle after reset deasserts.
- Reset asserted with a response pending: resp_valid is cleared and the pending response is lost.
- Address upper bits [31:ADDR_BITS] are passed to memory but ignored in the hazard compare.

Test Plan:
- Independent loads: lane 1 ld addr 4 tag 3, lane 2 ld addr 9 tag 7, mem preloaded 4->0xAAAA, 9->0xBBBB.
  -> Next cycle resp_valid_1/2 = 1, data 0xAAAA/tag 3 and 0xBBBB/tag 7; req_ready stays 1.
- Hazard split: lane 1 st addr 0x10 data 0x1234, lane 2 ld addr 0x10 tag 2.
  -> Cycle 0: memwrite_1 = 1, memread_2 = 0. Cycle 1: req_ready = 0, memread_2 = 1. Cycle 2: resp_valid_2 = 1, data 0x1234, tag 2. split_count = 1.
- Alias check: lane 1 st addr 0x105, lane 2 ld addr 0x005.
  -> Split occurs, because the low 8 bits match.
- Reverse order no split: lane 1 ld addr 8 (old 0x55), lane 2 st addr 8 data 0x77.
  -> req_ready stays 1; resp_data_1 = 0x55; a later ld addr 8 returns 0x77.
- Dual store same word: st 0x11 and st 0x22 to addr 3.
  -> A following ld addr 3 returns 0x22; no split.
- Reset in SPLIT: trigger a hazard, assert reset in the SPLIT cycle.
  -> No memread_2 and no resp_valid_2; split_count = 0; req_ready = 1 after release.

Source files
------------

// File: rtl/dual_lsu.sv
// Dual-lane load/store unit for the MEM stage: drives both data-memory ports,
// tracks the 1-cycle read latency and splits store(lane 1)->load(lane 2) same-word pairs.
module dual_lsu #(
   parameter int TAG_W     = 5,
   parameter int ADDR_BITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_1,
   input  logic             req_we_1,
   input  logic [31:0]      req_addr_1,
   input  logic [31:0]      req_wdata_1,
   input  logic [TAG_W-1:0] req_tag_1,
   input  logic             req_valid_2,
   input  logic             req_we_2,
   input  logic [31:0]      req_addr_2,
   input  logic [31:0]      req_wdata_2,
   input  logic [TAG_W-1:0] req_tag_2,
   output logic             req_ready,
   output logic [31:0]      mem_address_1,
   output logic [31:0]      mem_address_2,
   output logic [31:0]      mem_write_data_1,
   output logic [31:0]      mem_write_data_2,
   output logic             mem_memwrite_1,
   output logic             mem_memwrite_2,
   output logic             mem_memread_1,
   output logic             mem_memread_2,
   input  logic [31:0]      mem_read_data_1,
   input  logic [31:0]      mem_read_data_2,
   output logic             resp_valid_1,
   output logic             resp_valid_2,
   output logic [31:0]      resp_data_1,
   output logic [31:0]      resp_data_2,
   output logic [TAG_W-1:0] resp_tag_1,
   output logic [TAG_W-1:0] resp_tag_2,
   output logic [15:0]      split_count
);

   typedef enum logic {RUN = 1'b0, SPLIT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [31:0]      def_addr_q, def_addr_d;
   logic [TAG_W-1:0] def_tag_q, def_tag_d;
   logic [15:0]      split_count_q, split_count_d;
   logic             resp_valid_1_q, resp_valid_2_q;
   logic [TAG_W-1:0] resp_tag_1_q, resp_tag_2_q;

   logic             hazard_s;
   logic [31:0]      addr_1_s, addr_2_s, wdata_1_s, wdata_2_s;
   logic             we_1_s, we_2_s, rd_1_s, rd_2_s;
   logic [TAG_W-1:0] issue_tag_2_s;

   // Port steering, hazard split and deferred-load bookkeeping.
   always_comb begin
      hazard_s      = req_valid_1 & req_we_1 & req_valid_2 & ~req_we_2 &
                      (req_addr_1[ADDR_BITS-1:0] == req_addr_2[ADDR_BITS-1:0]);
      state_d       = state_q;
      def_addr_d    = def_addr_q;
      def_tag_d     = def_tag_q;
      split_count_d = split_count_q;
      addr_1_s      = 32'd0;
      addr_2_s      = 32'd0;
      wdata_1_s     = 32'd0;
      wdata_2_s     = 32'd0;
      we_1_s        = 1'b0;
      we_2_s        = 1'b0;
      rd_1_s        = 1'b0;
      rd_2_s        = 1'b0;
      issue_tag_2_s = req_tag_2;
      case (state_q)
         RUN: begin
            addr_1_s  = req_addr_1;
            wdata_1_s = req_wdata_1;
            we_1_s    = req_valid_1 & req_we_1;
            rd_1_s    = req_valid_1 & ~req_we_1;
            if (hazard_s) begin
               def_addr_d = req_addr_2;
               def_tag_d  = req_tag_2;
               state_d    = SPLIT;
               if (split_count_q != 16'hFFFF) begin
                  split_count_d = split_count_q + 16'd1;
               end else begin
                  split_count_d = split_count_q;
               end
            end else begin
               addr_2_s  = req_addr_2;
               wdata_2_s = req_wdata_2;
               we_2_s    = req_valid_2 & req_we_2;
               rd_2_s    = req_valid_2 & ~req_we_2;
            end
         end
         SPLIT: begin
            // Lane inputs are ignored; only the deferred load goes out.
            addr_2_s      = def_addr_q;
            rd_2_s        = 1'b1;
            issue_tag_2_s = def_tag_q;
            state_d       = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Strobes are suppressed while reset is held, which also drops a deferred load.
   assign mem_address_1    = addr_1_s;
   assign mem_address_2    = addr_2_s;
   assign mem_write_data_1 = wdata_1_s;
   assign mem_write_data_2 = wdata_2_s;
   assign mem_memwrite_1   = we_1_s & ~reset;
   assign mem_memwrite_2   = we_2_s & ~reset;
   assign mem_memread_1    = rd_1_s & ~reset;
   assign mem_memread_2    = rd_2_s & ~reset;

   assign req_ready    = (state_q == RUN);
   assign resp_valid_1 = resp_valid_1_q;
   assign resp_valid_2 = resp_valid_2_q;
   assign resp_tag_1   = resp_tag_1_q;
   assign resp_tag_2   = resp_tag_2_q;
   assign resp_data_1  = mem_read_data_1;
   assign resp_data_2  = mem_read_data_2;
   assign split_count  = split_count_q;

   // State, deferred request, split counter and response tracking registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         def_addr_q     <= 32'd0;
         def_tag_q      <= {TAG_W{1'b0}};
         split_count_q  <= 16'd0;
         resp_valid_1_q <= 1'b0;
         resp_valid_2_q <= 1'b0;
         resp_tag_1_q   <= {TAG_W{1'b0}};
         resp_tag_2_q   <= {TAG_W{1'b0}};
      end else begin
         state_q        <= state_d;
         def_addr_q     <= def_addr_d;
         def_tag_q      <= def_tag_d;
         split_count_q  <= split_count_d;
         resp_valid_1_q <= rd_1_s;
         resp_valid_2_q <= rd_2_s;
         if (rd_1_s) begin
            resp_tag_1_q <= req_tag_1;
         end
         if (rd_2_s) begin
            resp_tag_2_q <= issue_tag_2_s;
         end
      end
   end

endmodule

// File: tb/tb_dual_lsu.sv
// Directed bench for dual_lsu: dual-port registered-read memory model plus
// per-lane response scoreboards filled from a reference memory image.
module tb_dual_lsu;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid_1, req_we_1, req_valid_2, req_we_2;
   logic [31:0]      req_addr_1, req_wdata_1, req_addr_2, req_wdata_2;
   logic [TAG_W-1:0] req_tag_1, req_tag_2;
   logic             req_ready;
   logic [31:0]      mem_address_1, mem_address_2, mem_write_data_1, mem_write_data_2;
   logic             mem_memwrite_1, mem_memwrite_2, mem_memread_1, mem_memread_2;
   logic [31:0]      mem_read_data_1, mem_read_data_2;
   logic             resp_valid_1, resp_valid_2;
   logic [31:0]      resp_data_1, resp_data_2;
   logic [TAG_W-1:0] resp_tag_1, resp_tag_2;
   logic [15:0]      split_count;

   always #5 clk = ~clk;

   dual_lsu #(.TAG_W(TAG_W), .ADDR_BITS(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_addr_1(req_addr_1),
      .req_wdata_1(req_wdata_1), .req_tag_1(req_tag_1),
      .req_valid_2(req_valid_2), .req_we_2(req_we_2), .req_addr_2(req_addr_2),
      .req_wdata_2(req_wdata_2), .req_tag_2(req_tag_2),
      .req_ready(req_ready),
      .mem_address_1(mem_address_1), .mem_address_2(mem_address_2),
      .mem_write_data_1(mem_write_data_1), .mem_write_data_2(mem_write_data_2),
      .mem_memwrite_1(mem_memwrite_1), .mem_memwrite_2(mem_memwrite_2),
      .mem_memread_1(mem_memread_1), .mem_memread_2(mem_memread_2),
      .mem_read_data_1(mem_read_data_1), .mem_read_data_2(mem_read_data_2),
      .resp_valid_1(resp_valid_1), .resp_valid_2(resp_valid_2),
      .resp_data_1(resp_data_1), .resp_data_2(resp_data_2),
      .resp_tag_1(resp_tag_1), .resp_tag_2(resp_tag_2),
      .split_count(split_count)
   );

   // Dual-port memory with registered read; port 2 write lands last on a collision.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_memwrite_1) mem[mem_address_1[7:0]] <= mem_write_data_1;
      if (mem_memwrite_2) mem[mem_address_2[7:0]] <= mem_write_data_2;
      if (mem_memread_1)  mem_read_data_1 <= mem[mem_address_1[7:0]];
      if (mem_memread_2)  mem_read_data_2 <= mem[mem_address_2[7:0]];
   end

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } resp_t;

   resp_t       q1[$];
   resp_t       q2[$];
   logic [31:0] ref_mem [0:255];
   int          exp_split = 0;
   int          checks    = 0;
   int          failures  = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic chkb(input string name, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", name, obs, exp);
      end
   endtask

   // Response monitor: every pulse must match the head of its lane scoreboard.
   always @(negedge clk) begin
      resp_t e;
      if (!reset) begin
         if (resp_valid_1) begin
            if (q1.size() == 0) begin
               chkb("resp1_unexpected", resp_valid_1, 1'b0);
            end else begin
               e = q1.pop_front();
               chk("resp1_data", resp_data_1, e.data);
               chk("resp1_tag", {27'd0, resp_tag_1}, {27'd0, e.tag});
            end
         end
         if (resp_valid_2) begin
            if (q2.size() == 0) begin
               chkb("resp2_unexpected", resp_valid_2, 1'b0);
            end else begin
               e = q2.pop_front();
               chk("resp2_data", resp_data_2, e.data);
               chk("resp2_tag", {27'd0, resp_tag_2}, {27'd0, e.tag});
            end
         end
      end
   end

   task automatic drive(input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic [TAG_W-1:0] t1, input logic v2, input logic we2,
                        input logic [31:0] a2, input logic [31:0] d2, input logic [TAG_W-1:0] t2);
      req_valid_1 = v1; req_we_1 = we1; req_addr_1 = a1; req_wdata_1 = d1; req_tag_1 = t1;
      req_valid_2 = v2; req_we_2 = we2; req_addr_2 = a2; req_wdata_2 = d2; req_tag_2 = t2;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   // One request pair in RUN; a hazard pair also covers its SPLIT cycle.
   task automatic pair(input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [TAG_W-1:0] t1, input logic v2, input logic we2,
                       input logic [31:0] a2, input logic [31:0] d2, input logic [TAG_W-1:0] t2);
      logic  hz;
      resp_t r;
      hz = v1 & we1 & v2 & ~we2 & (a1[7:0] == a2[7:0]);
      if (v1 && !we1) begin r.tag = t1; r.data = ref_mem[a1[7:0]]; q1.push_back(r); end
      if (v2 && !we2 && !hz) begin r.tag = t2; r.data = ref_mem[a2[7:0]]; q2.push_back(r); end
      if (v1 && we1) ref_mem[a1[7:0]] = d1;
      if (v2 && we2) ref_mem[a2[7:0]] = d2;
      if (hz) begin
         r.tag = t2; r.data = ref_mem[a2[7:0]]; q2.push_back(r);
      end
      @(posedge clk); #1;
      drive(v1, we1, a1, d1, t1, v2, we2, a2, d2, t2);
      #1;
      chkb("ready_run", req_ready, 1'b1);
      chkb("memwrite_1", mem_memwrite_1, v1 & we1);
      chkb("memread_1", mem_memread_1, v1 & ~we1);
      chkb("memwrite_2", mem_memwrite_2, v2 & we2 & ~hz);
      chkb("memread_2", mem_memread_2, v2 & ~we2 & ~hz);
      if (v1) chk("address_1", mem_address_1, a1);
      if (v1 && we1) chk("wdata_1", mem_write_data_1, d1);
      if (v2 && !hz) chk("address_2", mem_address_2, a2);
      if (v2 && we2) chk("wdata_2", mem_write_data_2, d2);
      if (hz) begin
         exp_split++;
         @(posedge clk); #1;
         // Conflicting traffic in the SPLIT cycle must be ignored.
         drive(1'b1, 1'b1, 32'h55, 32'hDEAD, 5'd1, 1'b1, 1'b0, 32'h66, 32'd0, 5'd1);
         #1;
         chkb("ready_split", req_ready, 1'b0);
         chkb("split_memread_2", mem_memread_2, 1'b1);
         chkb("split_memwrite_2", mem_memwrite_2, 1'b0);
         chkb("split_memwrite_1", mem_memwrite_1, 1'b0);
         chkb("split_memread_1", mem_memread_1, 1'b0);
         chk("split_address_2", mem_address_2, a2);
         chk("split_count", {16'd0, split_count}, exp_split);
      end else begin
         chk("split_count", {16'd0, split_count}, exp_split);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      chkb("rst_resp_valid_1", resp_valid_1, 1'b0);
      chkb("rst_resp_valid_2", resp_valid_2, 1'b0);
      chk("rst_resp_tag_1", {27'd0, resp_tag_1}, 32'd0);
      chk("rst_resp_tag_2", {27'd0, resp_tag_2}, 32'd0);
      chk("rst_split_count", {16'd0, split_count}, 32'd0);
      chkb("rst_ready", req_ready, 1'b1);
      chkb("rst_memread_2", mem_memread_2, 1'b0);
      reset = 1'b0;

      // Preload through the DUT.
      pair(1'b1, 1'b1, 32'd4, 32'hAAAA, 5'd0, 1'b1, 1'b1, 32'd9, 32'hBBBB, 5'd0);
      pair(1'b1, 1'b1, 32'd8, 32'h55, 5'd0, 1'b1, 1'b1, 32'd3, 32'h0, 5'd0);
      // Independent loads, then back-to-back loads.
      pair(1'b1, 1'b0, 32'd4, 32'd0, 5'd3, 1'b1, 1'b0, 32'd9, 32'd0, 5'd7);
      pair(1'b1, 1'b0, 32'd9, 32'd0, 5'd1, 1'b1, 1'b0, 32'd4, 32'd0, 5'd2);
      idle();
      // Hazard split.
      pair(1'b1, 1'b1, 32'h10, 32'h1234, 5'd0, 1'b1, 1'b0, 32'h10, 32'd0, 5'd2);
      idle();
      // Alias through low address bits.
      pair(1'b1, 1'b1, 32'h105, 32'hCAFE, 5'd0, 1'b1, 1'b0, 32'h005, 32'd0, 5'd4);
      // Load then store same word: no split, old value returned.
      pair(1'b1, 1'b0, 32'd8, 32'd0, 5'd5, 1'b1, 1'b1, 32'd8, 32'h77, 5'd0);
      pair(1'b1, 1'b0, 32'd8, 32'd0, 5'd6, 1'b1, 1'b0, 32'h10, 32'd0, 5'd8);
      // Dual store same word: lane 2 wins.
      pair(1'b1, 1'b1, 32'd3, 32'h11, 5'd0, 1'b1, 1'b1, 32'd3, 32'h22, 5'd0);
      pair(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd3, 32'd0, 5'd10);
      idle();

      // Reset asserted during SPLIT drops the deferred load.
      ref_mem[8'h20] = 32'h99;
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 32'h20, 32'h99, 5'd0, 1'b1, 1'b0, 32'h20, 32'd0, 5'd9);
      #1;
      chkb("rs_memwrite_1", mem_memwrite_1, 1'b1);
      chkb("rs_memread_2", mem_memread_2, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      #1;
      chkb("rs_in_reset_memread_2", mem_memread_2, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_split = 0;
      #1;
      chkb("rs_ready", req_ready, 1'b1);
      chkb("rs_resp_valid_2", resp_valid_2, 1'b0);
      chk("rs_split_count", {16'd0, split_count}, 32'd0);
      @(posedge clk); #1;
      chkb("rs_resp_valid_2_late", resp_valid_2, 1'b0);
      chkb("rs_memread_2_late", mem_memread_2, 1'b0);

      // Normal operation after reset; the store before reset did land.
      pair(1'b1, 1'b0, 32'h10, 32'd0, 5'd12, 1'b1, 1'b0, 32'h20, 32'd0, 5'd11);
      repeat (3) idle();
      chk("q1_drained", q1.size(), 32'd0);
      chk("q2_drained", q2.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
